// File: rtl/hdmi_mode_sequencer.sv
// ---------------------------------------------------------------------------
// hdmi_mode_sequencer
//
// Selects one of NUM_MODES parallel HDMI timing/symbol streams and forwards it
// to the TMDS serializer. A mode change is applied only at a frame boundary
// (cx==0 && cy==0) of the requested mode, so the sink never sees a torn frame.
// The link can optionally be muted for a few frames after a switch so the
// sink can relock cleanly.
//
// Optional feature macro: HDMI_MODE_SWITCH_MUTE_EN
//   defined     : MUTE state present; MUTE_FRAMES frames of BLANK symbols of
//                 the new mode follow every real mode change.
//   not defined : MUTE state absent and MUTE_FRAMES ignored; the switch goes
//                 live immediately at the target frame start.
//
// Parameters
//   NUM_MODES     number of parallel timing generators (>= 2)
//   NUM_CHANNELS  TMDS data channels per stream
//   MUTE_FRAMES   blank frames after a switch (0 = none)
//   MODE_BITS     width of mode_req / mode_active
//
// Ports (all on rising edge of clk_pixel, reset synchronous active-high)
//   clk_pixel    in   pixel clock
//   reset        in   synchronous reset
//   mode_req     in   requested mode index (>= NUM_MODES is ignored)
//   tmds_in      in   mode m, channel c at [(m*NUM_CHANNELS+c)*10 +: 10]
//   cx_in        in   mode m x position at [m*11 +: 11]
//   cy_in        in   mode m y position at [m*10 +: 10]
//   tmds_out     out  selected or blanked symbols (registered)
//   cx, cy       out  selected mode position (registered)
//   mode_active  out  mode currently driving tmds_out
//   switching    out  high while waiting for a frame start or muting
// ---------------------------------------------------------------------------
module hdmi_mode_sequencer #(
  parameter int NUM_MODES    = 2,
  parameter int NUM_CHANNELS = 3,
  parameter int MUTE_FRAMES  = 2,
  parameter int MODE_BITS    = $clog2(NUM_MODES)
) (
  input  logic                                clk_pixel,
  input  logic                                reset,
  input  logic [MODE_BITS-1:0]                mode_req,
  input  logic [NUM_MODES*NUM_CHANNELS*10-1:0] tmds_in,
  input  logic [NUM_MODES*11-1:0]             cx_in,
  input  logic [NUM_MODES*10-1:0]             cy_in,
  output logic [NUM_CHANNELS*10-1:0]          tmds_out,
  output logic [10:0]                         cx,
  output logic [9:0]                          cy,
  output logic [MODE_BITS-1:0]                mode_active,
  output logic                                switching
);

  localparam int SYM_W = NUM_CHANNELS * 10;

  // Control-period symbol with C0=C1=0, sent on every channel while blanked.
  localparam logic [9:0]       BLANK_SYM = 10'b1101010100;
  localparam logic [SYM_W-1:0] BLANK_BUS = {NUM_CHANNELS{BLANK_SYM}};

  // One extra bit so that the comparison also works when NUM_MODES is a power of two.
  localparam logic [MODE_BITS:0] MODE_LIMIT = (MODE_BITS + 1)'(NUM_MODES);

`ifdef HDMI_MODE_SWITCH_MUTE_EN
  localparam int              MC_W      = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
  localparam logic [MC_W-1:0] MUTE_LAST = MC_W'((MUTE_FRAMES > 0) ? (MUTE_FRAMES - 1) : 0);
  localparam logic [MC_W-1:0] MUTE_FULL = MC_W'(MUTE_FRAMES);
  localparam bit              MUTE_ON   = (MUTE_FRAMES > 0);
`endif

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
`ifdef HDMI_MODE_SWITCH_MUTE_EN
    MUTE     = 2'd2,
`endif
    WAIT_SOF = 2'd1
  } state_t;

  state_t               state_r;
  logic [MODE_BITS-1:0] target_r;
  // Set when the link is showing BLANK instead of mode_active's live symbols
  // (after reset, or after a mute was abandoned for a new target).
  logic                 blank_hold_r;
`ifdef HDMI_MODE_SWITCH_MUTE_EN
  logic [MC_W-1:0]      mute_cnt_r;
`endif

  logic [SYM_W-1:0]     active_tmds_s;
  logic [10:0]          active_cx_s;
  logic [9:0]           active_cy_s;
  logic [SYM_W-1:0]     target_tmds_s;
  logic [10:0]          target_cx_s;
  logic [9:0]           target_cy_s;
  logic                 sof_target_s;
  logic                 sof_active_s;
  logic                 req_valid_s;

  // Stream selection and frame-start detection for the active and target modes.
  always_comb begin
    active_tmds_s = '0;
    active_cx_s   = 11'd0;
    active_cy_s   = 10'd0;
    target_tmds_s = '0;
    target_cx_s   = 11'd0;
    target_cy_s   = 10'd0;
    sof_target_s  = 1'b0;
    sof_active_s  = 1'b0;
    for (int m = 0; m < NUM_MODES; m++) begin
      active_tmds_s = (mode_active == MODE_BITS'(m)) ? tmds_in[m*SYM_W +: SYM_W] : active_tmds_s;
      active_cx_s   = (mode_active == MODE_BITS'(m)) ? cx_in[m*11 +: 11]        : active_cx_s;
      active_cy_s   = (mode_active == MODE_BITS'(m)) ? cy_in[m*10 +: 10]        : active_cy_s;
      target_tmds_s = (target_r == MODE_BITS'(m))    ? tmds_in[m*SYM_W +: SYM_W] : target_tmds_s;
      target_cx_s   = (target_r == MODE_BITS'(m))    ? cx_in[m*11 +: 11]        : target_cx_s;
      target_cy_s   = (target_r == MODE_BITS'(m))    ? cy_in[m*10 +: 10]        : target_cy_s;
      sof_active_s  = (mode_active == MODE_BITS'(m)) ?
                      ((cx_in[m*11 +: 11] == 11'd0) && (cy_in[m*10 +: 10] == 10'd0)) : sof_active_s;
      sof_target_s  = (target_r == MODE_BITS'(m)) ?
                      ((cx_in[m*11 +: 11] == 11'd0) && (cy_in[m*10 +: 10] == 10'd0)) : sof_target_s;
    end
    req_valid_s = ({1'b0, mode_req} < MODE_LIMIT);
  end

  // Mode-switch FSM with registered stream outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_r      <= WAIT_SOF;
      target_r     <= '0;
      mode_active  <= '0;
      blank_hold_r <= 1'b1;
`ifdef HDMI_MODE_SWITCH_MUTE_EN
      mute_cnt_r   <= '0;
`endif
      tmds_out     <= BLANK_BUS;
      cx           <= 11'd0;
      cy           <= 10'd0;
      switching    <= 1'b1;
    end else begin
      case (state_r)
        ACTIVE: begin
          tmds_out  <= active_tmds_s;
          cx        <= active_cx_s;
          cy        <= active_cy_s;
          switching <= 1'b0;
          if (req_valid_s && (mode_req != mode_active)) begin
            target_r     <= mode_req;
            blank_hold_r <= 1'b0;
            state_r      <= WAIT_SOF;
            switching    <= 1'b1;
          end else begin
            state_r <= ACTIVE;
          end
        end

        WAIT_SOF: begin
          // Old mode keeps running until the target reaches its frame start.
          tmds_out  <= blank_hold_r ? BLANK_BUS : active_tmds_s;
          cx        <= active_cx_s;
          cy        <= active_cy_s;
          switching <= 1'b1;
          if (req_valid_s && (mode_req != target_r)) begin
            // A request change beats a coincident target SOF.
            target_r <= mode_req;
            if ((mode_req == mode_active) && !blank_hold_r) begin
              // Old mode is still live on the link: just cancel the switch.
              state_r   <= ACTIVE;
              switching <= 1'b0;
            end else begin
              state_r <= WAIT_SOF;
            end
          end else if (sof_target_s) begin
            // The SOF cycle itself already shows the target mode.
            mode_active  <= target_r;
            blank_hold_r <= 1'b0;
            cx           <= target_cx_s;
            cy           <= target_cy_s;
`ifdef HDMI_MODE_SWITCH_MUTE_EN
            // Re-entering the same timing after reset needs no relock time.
            if (MUTE_ON && (target_r != mode_active)) begin
              state_r    <= MUTE;
              mute_cnt_r <= '0;
              tmds_out   <= BLANK_BUS;
              switching  <= 1'b1;
            end else begin
              state_r   <= ACTIVE;
              tmds_out  <= target_tmds_s;
              switching <= 1'b0;
            end
`else
            state_r   <= ACTIVE;
            tmds_out  <= target_tmds_s;
            switching <= 1'b0;
`endif
          end else begin
            state_r <= WAIT_SOF;
          end
        end

`ifdef HDMI_MODE_SWITCH_MUTE_EN
        MUTE: begin
          tmds_out  <= BLANK_BUS;
          cx        <= active_cx_s;
          cy        <= active_cy_s;
          switching <= 1'b1;
          if (req_valid_s && (mode_req != mode_active)) begin
            // Link is already blank, so keep it blank while waiting again.
            target_r     <= mode_req;
            blank_hold_r <= 1'b1;
            mute_cnt_r   <= '0;
            state_r      <= WAIT_SOF;
          end else if (sof_active_s) begin
            if (mute_cnt_r >= MUTE_LAST) begin
              // Last muted frame is over: this SOF cycle goes live.
              mute_cnt_r <= MUTE_FULL;
              state_r    <= ACTIVE;
              tmds_out   <= active_tmds_s;
              switching  <= 1'b0;
            end else begin
              mute_cnt_r <= mute_cnt_r + MC_W'(1);
              state_r    <= MUTE;
            end
          end else begin
            state_r <= MUTE;
          end
        end
`endif

        default: begin
          // Unreachable encoding: recover to the reset behaviour.
          state_r      <= WAIT_SOF;
          target_r     <= '0;
          mode_active  <= '0;
          blank_hold_r <= 1'b1;
`ifdef HDMI_MODE_SWITCH_MUTE_EN
          mute_cnt_r   <= '0;
`endif
          tmds_out     <= BLANK_BUS;
          cx           <= 11'd0;
          cy           <= 10'd0;
          switching    <= 1'b1;
        end
      endcase
    end
  end

endmodule
